// File: rtl/mem_responder_pkg.sv
// Purpose: shared types and constants for the memory-strobe responder.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // Width of the wait-state counter (WAIT_CYCLES up to 15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_responder_ram.sv
// Purpose: single-port synchronous word RAM, DEPTH x DATA_W, contents not reset.
// Latency: write lands at the clock edge; read data is registered (one edge).
// Backpressure: none, accepts an access every cycle.
module mem_responder_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write-enable store plus read-before-write registered read port.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/mem_responder.sv
// Purpose: answers MemR/MemW strobes with a wait-stated RAM access and a ready pulse.
// Latency: o_ready WAIT_CYCLES+1 edges after the accept cycle begins; one request in flight.
// Backpressure: requests are only taken in IDLE; inputs held past o_ready are re-accepted.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ready,
    output logic              o_error,
    output logic              o_busy
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                enter_done;

    op_t                 op_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                err_q;

    logic                accept;
    logic                live_err;
    op_t                 live_op;

    op_t                 acc_op;
    logic [IDX_W-1:0]    acc_idx;
    logic [DATA_W-1:0]   acc_wdata;
    logic                acc_err;

    logic                ram_we;
    logic [DATA_W-1:0]   ram_rdata;
    logic                rd_fire_q;
    logic [DATA_W-1:0]   rd_hold;

    assign accept   = (state == IDLE) && (i_mem_read || i_mem_write);
    assign live_op  = (i_mem_write && !i_mem_read) ? OP_WR : OP_RD;
    assign live_err = (i_mem_read && i_mem_write) || i_addr[0] ||
                      ({1'b0, i_addr[ADDR_W-1:1]} >= ADDR_W'(DEPTH));

    // With zero wait states the access happens at the accept edge, so it must
    // use the live request; otherwise it uses the latched copy.
    assign acc_op    = (state == IDLE) ? live_op            : op_q;
    assign acc_idx   = (state == IDLE) ? i_addr[IDX_W:1]    : idx_q;
    assign acc_wdata = (state == IDLE) ? i_wdata            : wdata_q;
    assign acc_err   = (state == IDLE) ? live_err           : err_q;

    assign ram_we = enter_done && (acc_op == OP_WR) && !acc_err;

    // Read data is shown straight from the RAM register during DONE and held afterwards.
    assign o_rdata = rd_fire_q ? ram_rdata : rd_hold;

    // State register, counter, latched request and registered outputs.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= OP_RD;
            idx_q     <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            o_ready   <= 1'b0;
            o_error   <= 1'b0;
            o_busy    <= 1'b0;
            rd_fire_q <= 1'b0;
            rd_hold   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            if (accept) begin
                op_q    <= live_op;
                idx_q   <= i_addr[IDX_W:1];
                wdata_q <= i_wdata;
                err_q   <= live_err;
            end
            o_ready   <= enter_done;
            o_error   <= enter_done && acc_err;
            o_busy    <= (state_nxt != IDLE);
            rd_fire_q <= enter_done && (acc_op == OP_RD) && !acc_err;
            if (rd_fire_q) begin
                rd_hold <= ram_rdata;
            end
        end
    end

    // Next-state and wait counter; flags the edge that enters DONE.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_done = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nxt = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_nxt  = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt  = DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    mem_responder_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .CLK   (CLK),
        .we    (ram_we),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

endmodule
